// File: rtl/spi_cmd_regfile_if.sv
// spi_cmd_regfile_if: byte link between the SPI slave (master side) and the command regfile (slave side).
interface spi_cmd_regfile_if;
   logic       ss;
   logic [7:0] rx_data;
   logic       rx_rdy;
   logic [7:0] tx_data;
   logic       tx_latch;
   modport master (output ss, rx_data, rx_rdy, input tx_data, tx_latch);
   modport slave (input ss, rx_data, rx_rdy, output tx_data, tx_latch);
endinterface

// File: rtl/spi_cmd_regfile.sv
// spi_cmd_regfile: SPI byte command decoder with read/write bursts into a register bank.
// Optional SPI_CMD_WR_ECHO_EN returns the previous register contents during write bursts.
module spi_cmd_regfile #(
   parameter int ADDR_W = 3,
   parameter logic [7:0] RST_VAL = 8'h00,
   localparam int NUM_REGS = 2**ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst,
   spi_cmd_regfile_if.slave      spi,
   output logic [8*NUM_REGS-1:0] regs_flat,
   output logic                  wr_stb,
   output logic [ADDR_W-1:0]     wr_addr,
   output logic                  cmd_err
);
`ifdef SPI_CMD_WR_ECHO_EN
   localparam bit ECHO = 1'b1;
`else
   localparam bit ECHO = 1'b0;
`endif
   typedef enum logic [2:0] {IDLE, CMD, WRITE, READ, ERR} state_t;
   state_t state, state_n;
   logic [7:0] regs [NUM_REGS];
   logic [ADDR_W-1:0] ptr, ptr_n, ptr_inc, wr_addr_n;
   logic [7:0] tx_data_n;
   logic ss_q, tx_latch_n, wr_stb_n, cmd_err_n, wr_en;
   assign ptr_inc = ptr + 1'b1;
   for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
      assign regs_flat[8*i +: 8] = regs[i];
   end
   always_comb begin
      state_n = state;
      ptr_n = ptr;
      tx_data_n = spi.tx_data;
      tx_latch_n = 1'b0;
      wr_stb_n = 1'b0;
      wr_addr_n = wr_addr;
      cmd_err_n = cmd_err;
      wr_en = 1'b0;
      if (state == IDLE) begin
         if (ss_q && !spi.ss) begin
            state_n = CMD;
            cmd_err_n = 1'b0;
         end
      end else if (spi.ss) begin
         state_n = IDLE;
      end else if (spi.rx_rdy) begin
         unique case (state)
            CMD: begin
               ptr_n = spi.rx_data[ADDR_W-1:0];
               if (|spi.rx_data[6:ADDR_W]) begin
                  state_n = ERR;
                  cmd_err_n = 1'b1;
               end else if (spi.rx_data[7]) begin
                  state_n = READ;
                  tx_data_n = regs[spi.rx_data[ADDR_W-1:0]];
                  tx_latch_n = 1'b1;
               end else begin
                  state_n = WRITE;
               end
            end
            WRITE: begin
               wr_en = 1'b1;
               wr_stb_n = 1'b1;
               wr_addr_n = ptr;
               ptr_n = ptr_inc;
               tx_latch_n = ECHO;
               tx_data_n = ECHO ? regs[ptr] : spi.tx_data;
            end
            READ: begin
               ptr_n = ptr_inc;
               tx_data_n = regs[ptr_inc];
               tx_latch_n = 1'b1;
            end
            default: ;
         endcase
      end
   end
   // ss_q is a plain synchroniser stage: after reset a new frame still needs a fresh falling edge of ss
   always_ff @(posedge clk) begin
      ss_q <= spi.ss;
      if (rst) begin
         state <= IDLE;
         ptr <= '0;
         spi.tx_data <= 8'h00;
         spi.tx_latch <= 1'b0;
         wr_stb <= 1'b0;
         wr_addr <= '0;
         cmd_err <= 1'b0;
         for (int k = 0; k < NUM_REGS; k++) regs[k] <= RST_VAL;
      end else begin
         state <= state_n;
         ptr <= ptr_n;
         spi.tx_data <= tx_data_n;
         spi.tx_latch <= tx_latch_n;
         wr_stb <= wr_stb_n;
         wr_addr <= wr_addr_n;
         cmd_err <= cmd_err_n;
         if (wr_en) regs[ptr] <= spi.rx_data;
      end
   end
endmodule

// File: doc/spi_cmd_regfile.md
Name: spi_cmd_regfile

Overview:
- Byte-level command decoder and register file placed directly downstream of the SPI slave.
- Consumes each received byte (the slave's `data` and `rdy`) and decodes read/write burst commands into a small register bank.
- Returns read data to the slave via `tx_data`/`tx_latch`; the slave shifts that byte out on `miso` in the next byte slot.
- Gives the SPI link a usable register-access protocol for the rest of the design.

Parameters:
- ADDR_W, 3, register address width; NUM_REGS = 2**ADDR_W (8 by default).
- RST_VAL, 8'h00, reset value of every register.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ss  in  1  SPI slave select, active low; high = no frame.
- rx_data  in  8  received byte from the SPI slave; valid only when rx_rdy=1.
- rx_rdy  in  1  one-cycle strobe: rx_data holds a complete byte.
- tx_data  out  8  byte for the slave to transmit next.
- tx_latch  out  1  one-cycle pulse: slave loads tx_data into its shift register.
- regs_flat  out  8*NUM_REGS  all registers; reg[i] = bits [8i+7:8i].
- wr_stb  out  1  one-cycle pulse on each register write.
- wr_addr  out  ADDR_W  address of the write flagged by wr_stb.
- cmd_err  out  1  set on an illegal command byte.

Behaviour:
- Reset (rst=1 at a clk edge):
  - all regs = RST_VAL; tx_data=0x00; tx_latch=0; wr_stb=0; wr_addr=0; cmd_err=0; state=IDLE.
  - Reset wins over every other event, including mid-burst.
- ss is registered once (ss_q); a frame start is ss_q=1 and ss=0.
- Command byte (first byte of a frame):
  - bit7 = R/nW (1 = read).
  - bits[ADDR_W-1:0] = start address.
  - bits[6:ADDR_W] are reserved and must be 0.
- FSM states: IDLE, CMD, WRITE, READ, ERR.
  - IDLE: waits for a frame start -> CMD; cmd_err cleared on that same edge.
  - CMD, on rx_rdy:
    - reserved bits nonzero -> ERR, cmd_err=1.
    - read -> READ, ptr=addr; the next cycle drives tx_data=reg[addr] and tx_latch=1.
    - write -> WRITE, ptr=addr.
  - WRITE, on rx_rdy:
    - reg[ptr] <= rx_data, visible on regs_flat the next cycle.
    - wr_stb=1 and wr_addr=ptr in that same next cycle.
    - ptr <= ptr+1, wrapping modulo NUM_REGS (7 -> 0).
  - READ, on rx_rdy (dummy byte; its value is ignored):
    - ptr <= ptr+1 (wrap).
    - Next cycle: tx_data = reg[ptr+1], tx_latch=1.
  - ERR: all rx_rdy are ignored; no writes and no tx_latch.
- ss=1 in any non-IDLE state -> IDLE on the next edge. An rx_rdy arriving in the same cycle as ss=1 is discarded.
- Latency: 1 cycle from the rx_rdy edge to the register update, wr_stb, or tx_latch.
- tx_latch and wr_stb are never high for more than one cycle. tx_data holds its value between latches.
- Outside an active read (or the echo case below), tx_latch=0 and tx_data is unchanged.
- Back-to-back rx_rdy on consecutive cycles must be handled; each strobe is one byte.

Optional Feature:
- Macro: SPI_CMD_WR_ECHO_EN.
- Defined: in WRITE, each data byte also produces tx_latch=1, with tx_data = the old value of reg[ptr] (the value before the write), in the same cycle as wr_stb. The master thus reads back the previous contents during a write burst.
- Undefined: tx_latch stays 0 in WRITE and tx_data is untouched.

Test Plan:
- Write single: ss 1->0; bytes 0x02, 0x5B; ss->1 -> reg[2]=0x5B; wr_stb for 1 cycle with wr_addr=2; all other regs 0x00.
- Write burst with wrap: bytes 0x06, 0x11, 0x22, 0x33 -> reg6=0x11, reg7=0x22, reg0=0x33; three wr_stb pulses with wr_addr 6, 7, 0.
- Read burst: preload reg3=0xA1, reg4=0xB2; bytes 0x83, 0xFF, 0xFF -> three tx_latch pulses with tx_data 0xA1, 0xB2, reg5 (0x00); no wr_stb.
- Illegal command: byte 0x48 then 0x77 -> cmd_err=1; no write; no tx_latch. The next frame start clears cmd_err.
- Abort and reset: write cmd 0x01, then ss->1 in the same cycle as an rx_rdy with 0x99 -> reg1 unchanged. rst asserted mid-burst -> all regs 0x00, state IDLE.
- With SPI_CMD_WR_ECHO_EN: reg2=0x5B, then bytes 0x02, 0xC3 -> tx_latch with tx_data=0x5B, concurrent with wr_stb; reg2=0xC3.
